nb_info_dram_arbiter: RTL

- Single-port controller for one distributed neighbour-info RAM (intra pred mode, ref_idx, mv storage).
- The RAM has asynchronous read and synchronous, en-qualified write.
- Shares the RAM port between a write client (decode results) and a read client (prediction/mvp fetch) using round-robin arbitration.
- Owns a clear sequencer that fills the whole RAM with a constant at picture/slice start.
- Sits between the CU-level info producers and consumers and one RAM instance.

---
 rtl/nb_info_dram_arbiter_pkg.sv | 12 +
 rtl/nb_info_dram_arbiter_clr_seq.sv | 57 +++++
 rtl/nb_info_dram_arbiter.sv | 94 +++++++++
 3 files changed

// File: rtl/nb_info_dram_arbiter_pkg.sv
// Shared encodings for the neighbour-info RAM port arbiter and its clear sequencer.
package nb_info_dram_arbiter_pkg;
    typedef enum logic {
        S_SERVE = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    typedef enum logic {
        GRANT_RD = 1'b0,
        GRANT_WR = 1'b1
    } grant_t;
endpackage

// File: rtl/nb_info_dram_arbiter_clr_seq.sv
// Clear sequencer: sweeps every RAM address once, writing a stored fill word.
module nb_info_clr_seq
    import nb_info_dram_arbiter_pkg::*;
#(
    parameter int addr_bits = 8,
    parameter int data_bits = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_start,
    input  logic [data_bits-1:0] clr_value,
    output logic                 o_active,
    output logic [addr_bits-1:0] o_addr,
    output logic [data_bits-1:0] o_data,
    output logic                 clr_busy,
    output logic                 clr_done
);
    state_t               r_state;
    logic [addr_bits-1:0] r_cnt;
    logic [data_bits-1:0] r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_SERVE;
            r_cnt    <= '0;
            r_value  <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (r_state)
                S_SERVE: begin
                    if (clr_start) begin
                        r_value  <= clr_value;
                        r_cnt    <= '0;
                        r_state  <= S_CLEAR;
                        clr_busy <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    // clr_start is deliberately ignored here; the sweep never restarts.
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == {addr_bits{1'b1}}) begin
                        r_state  <= S_SERVE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end
                end
                default: r_state <= S_SERVE;
            endcase
        end
    end

    assign o_active = (r_state == S_CLEAR);
    assign o_addr   = r_cnt;
    assign o_data   = r_value;
endmodule

// File: rtl/nb_info_dram_arbiter.sv
// Single-port neighbour-info RAM controller: round-robin write/read arbitration plus clear sweep.
module nb_info_dram_arbiter
    import nb_info_dram_arbiter_pkg::*;
#(
    parameter int addr_bits = 8,
    parameter int data_bits = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_start,
    input  logic [data_bits-1:0] clr_value,
    output logic                 clr_busy,
    output logic                 clr_done,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [addr_bits-1:0] wr_addr,
    input  logic [data_bits-1:0] wr_data,
    input  logic                 rd_valid,
    output logic                 rd_ready,
    input  logic [addr_bits-1:0] rd_addr,
    output logic                 rd_data_valid,
    output logic [data_bits-1:0] rd_data,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [addr_bits-1:0] ram_addr,
    output logic [data_bits-1:0] ram_din,
    input  logic [data_bits-1:0] ram_dout
);
    logic                 w_clr_active;
    logic [addr_bits-1:0] w_clr_addr;
    logic [data_bits-1:0] w_clr_data;
    grant_t               r_last_grant;

    nb_info_clr_seq #(
        .addr_bits(addr_bits),
        .data_bits(data_bits)
    ) u_clr_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_start(clr_start),
        .clr_value(clr_value),
        .o_active (w_clr_active),
        .o_addr   (w_clr_addr),
        .o_data   (w_clr_data),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    // Under contention the client not served last wins, bounding any wait to one cycle.
    always_comb begin
        wr_ready = 1'b0;
        rd_ready = 1'b0;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (rst_n) begin
            if (w_clr_active) begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = w_clr_addr;
                ram_din  = w_clr_data;
            end else begin
                wr_ready = wr_valid && (!rd_valid || (r_last_grant == GRANT_RD));
                rd_ready = rd_valid && !wr_ready;
                if (wr_ready) begin
                    ram_en   = 1'b1;
                    ram_we   = 1'b1;
                    ram_addr = wr_addr;
                    ram_din  = wr_data;
                end else if (rd_ready) begin
                    ram_en   = 1'b1;
                    ram_addr = rd_addr;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant  <= GRANT_RD;
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
        end else begin
            if (wr_ready)
                r_last_grant <= GRANT_WR;
            else if (rd_ready)
                r_last_grant <= GRANT_RD;
            rd_data_valid <= rd_ready;
            if (rd_ready)
                rd_data <= ram_dout;
        end
    end
endmodule
